sb_merge_store: RTL and testbench
=================================

Name: sb_merge_store

Overview:
- Store-side counterpart of the byte-load extractor: takes sb/sh/sw requests from the MEM stage and writes them into a single-port, word-addressed data memory.
- Word stores are written directly.
- Byte and halfword stores do a read-modify-write: read the word, merge the lane, write it back.
- Asserts busy so the pipeline stalls while a store is in flight.

Parameters:
- ADDR_W, 10, word-address width of the data memory; the memory address is req_addr[ADDR_W+1:2].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  32  byte address.
- req_data  in  32  store data; the low byte/half is used for sb/sh.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- mem_addr  out  ADDR_W  word address to memory.
- mem_re  out  1  memory read strobe; synchronous read, data valid the next cycle.
- mem_rdata  in  32  memory read data.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  merged word to write.
- busy  out  1  request in flight (not IDLE).
- done  out  1  one-cycle pulse when a store completes or is rejected.
- err  out  1  one-cycle pulse, coincident with done, on misaligned or illegal size.

Behaviour:
- Reset (reset=0, async): state = IDLE. req_ready = 1. mem_re = mem_we = busy = done = err = 0. mem_addr and mem_wdata = 0. Request registers cleared.
- Accept: a request is accepted when req_valid && req_ready. addr, data and size are registered. Inputs are ignored outside IDLE.
- Misalignment check:
  - half with addr[0] = 1 → misaligned.
  - word with addr[1:0] != 0 → misaligned.
  - size 11 → illegal.
  - On any of these the state goes to ERR. ERR drives done = 1, err = 1, performs no memory access, and returns to IDLE.
- States: IDLE, RD, WT, WR, ERR.
  - IDLE→WR: aligned word.
  - IDLE→RD: aligned byte or half.
  - IDLE→ERR: misaligned or illegal.
  - RD: mem_re = 1, mem_addr = word address → WT.
  - WT: capture mem_rdata, merge into the write-data register → WR.
  - WR: mem_we = 1, mem_addr = word address, mem_wdata = merged word, done = 1 → IDLE.
  - ERR → IDLE.
- Merge, little-endian, lane selected by addr:
  - byte: lane k = addr[1:0]; bits [8k+7:8k] ← data[7:0], all other bits kept from the read word.
  - half: h = addr[1]; bits [16h+15:16h] ← data[15:0].
  - word: mem_wdata = data unchanged.
- Latency (done relative to the accept edge):
  - word: done in cycle +1.
  - byte/half: done in cycle +3 (RD, WT, WR).
  - error: done in cycle +1.
- Back-to-back: req_ready returns the cycle after WR/ERR, so at most one request is in flight. No same-cycle accept in WR.
- Strobes: mem_re and mem_we are never high together. Each is high for exactly one cycle per access.
- Reset mid-operation: immediately back to IDLE. Any pending strobe drops asynchronously. A store that has not reached WR leaves memory unmodified.
- Address wrap: bits above ADDR_W+1 are ignored; the address wraps modulo 2^ADDR_W words.

Optional Feature:
- Macro: SB_MERGE_FWD_EN.
- Defined: adds a one-entry last-write buffer (valid bit, word address, data), updated on every WR and cleared by reset. An aligned byte/half whose word address matches a valid entry skips RD/WT. It merges against the buffered data and goes IDLE→WR, so done arrives in cycle +1 and mem_re stays 0.
- Not defined: every byte/half uses the full RD/WT/WR sequence. No buffer logic is synthesised.

Test Plan:
- Word store: addr = 0x0000_0010, data = 0xDEADBEEF, size = 10 → done at +1; mem_we = 1, mem_addr = 4, mem_wdata = 0xDEADBEEF; mem_re never set.
- Byte store, memory word 4 = 0x11223344: addr = 0x12, data = 0x000000AB, size = 00 → mem_re at +1, mem_we at +3 with mem_wdata = 0x11AB3344; done = 1, err = 0.
- Half store to the same word: addr = 0x12, data = 0x0000CAFE, size = 01 → mem_wdata = 0xCAFE3344. Repeat with addr = 0x10 → 0x1122CAFE.
- Misaligned: half at addr = 0x13 and word at addr = 0x11 → each gives done = err = 1 at +1, with no mem_re or mem_we.
- Reset pulsed low during WT → busy = 0, req_ready = 1 immediately; mem_we never asserts; word 4 unchanged.
- With SB_MERGE_FWD_EN: write word 0x20 = 0xA5A5A5A5, then sb to addr 0x21 with data 0x3C → done at +1, no mem_re, mem_wdata = 0xA5A53CA5. Without the macro the same sequence completes at +3.

Source files
------------

// File: rtl/sb_merge_store.sv
// Store merge unit: sb/sh/sw into a single-port word memory, RMW for sub-word stores.
// Optional SB_MERGE_FWD_EN adds a one-entry last-write buffer so sub-word hits skip the read.
module sb_merge_store #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, RD, WT, WR, ERR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] waddr_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic [31:0]       data_q;
    logic [31:0]       wdata_q;
    logic              req_bad;
    logic              fwd_hit;
    logic [31:0]       fwd_base;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Little-endian lane merge; word size passes the store data through.
    function automatic logic [31:0] merge(input logic [31:0] base, input logic [31:0] d,
                                          input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] r;
        r = base;
        case (size)
            2'b00:   r[{lane, 3'b000} +: 8]     = d[7:0];
            2'b01:   r[{lane[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    assign req_bad = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

`ifdef SB_MERGE_FWD_EN
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [31:0]       fwd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else if (state == WR) begin
            fwd_valid <= 1'b1;
            fwd_addr  <= waddr_q;
            fwd_data  <= wdata_q;
        end
    end

    assign fwd_hit  = fwd_valid && (fwd_addr == req_addr[ADDR_W+1:2]);
    assign fwd_base = fwd_data;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_base = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) begin
                if (req_bad)                           state_nxt = ERR;
                else if (req_size == 2'b10 || fwd_hit) state_nxt = WR;
                else                                   state_nxt = RD;
            end
            RD:      state_nxt = WT;
            WT:      state_nxt = WR;
            WR:      state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // wdata_q is preloaded at accept (word data or forwarded merge); RMW overwrites it in WT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waddr_q <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                waddr_q <= req_addr[ADDR_W+1:2];
                lane_q  <= req_addr[1:0];
                size_q  <= req_size;
                data_q  <= req_data;
                wdata_q <= merge(fwd_base, req_data, req_addr[1:0], req_size);
            end
            if (state == WT) wdata_q <= merge(mem_rdata, data_q, lane_q, size_q);
        end
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            RD: begin
                mem_re   = 1'b1;
                mem_addr = waddr_q;
            end
            WR: begin
                mem_we    = 1'b1;
                mem_addr  = waddr_q;
                mem_wdata = wdata_q;
                done      = 1'b1;
            end
            ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sb_merge_store.sv
// Directed bench for sb_merge_store with a behavioural synchronous-read word memory.
module tb_sb_merge_store;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic [9:0]  mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata = '0;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        busy, done, err;

    logic [31:0] mem [0:1023];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          we_total = 0;

    int checks = 0;
    int errors = 0;

    int          done_cyc, re_cyc, we_cyc, re_cnt, we_cnt;
    logic        err_s, overlap, busy1, ready1;
    logic [9:0]  re_addr, we_addr;
    logic [31:0] we_data;

    sb_merge_store #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_total <= we_total + 1;
        end
        if (pl_we) mem[pl_addr] <= pl_data;
    end

    task automatic apply_reset();
        @(negedge clk); reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk); pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk); pl_we = 1'b0;
    endtask

    // Issues one request and records strobes per cycle after the accept edge until done.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!req_ready) begin errors++; $display("FAIL ready_wait: req_ready=%b required 1", req_ready); end
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
        @(posedge clk); #1;
        req_valid = 1'b0;
        done_cyc = 0; re_cyc = 0; we_cyc = 0; re_cnt = 0; we_cnt = 0;
        err_s = 1'b0; overlap = 1'b0; re_addr = '0; we_addr = '0; we_data = '0;
        busy1 = busy; ready1 = req_ready;
        for (int c = 1; c <= 10; c++) begin
            if (mem_re) begin re_cnt++; re_cyc = c; re_addr = mem_addr; end
            if (mem_we) begin we_cnt++; we_cyc = c; we_addr = mem_addr; we_data = mem_wdata; end
            if (mem_re && mem_we) overlap = 1'b1;
            if (done) begin done_cyc = c; err_s = err; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (done_cyc == 0) begin errors++; $display("FAIL done_timeout: no done within 10 cycles for addr %h", a); end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", req_ready); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rst_flags: busy/done/err got %b required 000", {busy, done, err}); end
        checks++; if ({mem_re, mem_we} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b required 00", {mem_re, mem_we}); end
        checks++; if (mem_addr !== 10'd0) begin errors++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_word();
        apply_reset();
        do_req(32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
        checks++; if (done_cyc !== 1) begin errors++; $display("FAIL word_latency: got %0d required 1", done_cyc); end
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL word_err: got %b required 0", err_s); end
        checks++; if (busy1 !== 1'b1 || ready1 !== 1'b0) begin errors++; $display("FAIL word_busy: busy=%b ready=%b required 1/0", busy1, ready1); end
        checks++; if (we_cnt !== 1 || we_addr !== 10'd4) begin errors++; $display("FAIL word_we: count %0d addr %h required 1/004", we_cnt, we_addr); end
        checks++; if (we_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_wdata: got %h required deadbeef", we_data); end
        checks++; if (re_cnt !== 0) begin errors++; $display("FAIL word_no_re: got %0d reads required 0", re_cnt); end
        @(posedge clk); #1;
        checks++; if (mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_mem: got %h required deadbeef", mem[4]); end
    endtask

    task automatic test_merge();
        logic [31:0] t_addr [5] = '{32'h12, 32'h13, 32'h10, 32'h12, 32'h10};
        logic [31:0] t_data [5] = '{32'hAB, 32'hAB, 32'hAB, 32'hCAFE, 32'hCAFE};
        logic [1:0]  t_size [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        logic [31:0] t_exp  [5] = '{32'h11AB3344, 32'hAB223344, 32'h112233AB, 32'hCAFE3344, 32'h1122CAFE};
        for (int i = 0; i < 5; i++) begin
            apply_reset();
            preload(10'd4, 32'h1122_3344);
            do_req(t_addr[i], t_data[i], t_size[i]);
            checks++; if (re_cyc !== 1 || re_addr !== 10'd4) begin errors++; $display("FAIL merge%0d_read: cycle %0d addr %h required 1/004", i, re_cyc, re_addr); end
            checks++; if (we_cyc !== 3 || done_cyc !== 3) begin errors++; $display("FAIL merge%0d_latency: we %0d done %0d required 3/3", i, we_cyc, done_cyc); end
            checks++; if (we_data !== t_exp[i]) begin errors++; $display("FAIL merge%0d_wdata: got %h required %h", i, we_data, t_exp[i]); end
            checks++; if (err_s !== 1'b0 || overlap !== 1'b0 || re_cnt !== 1 || we_cnt !== 1) begin errors++; $display("FAIL merge%0d_strobes: err %b overlap %b re %0d we %0d", i, err_s, overlap, re_cnt, we_cnt); end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] t_addr [4] = '{32'h13, 32'h11, 32'h12, 32'h10};
        logic [1:0]  t_size [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 4; i++) begin
            apply_reset();
            do_req(t_addr[i], 32'h5555_5555, t_size[i]);
            checks++; if (done_cyc !== 1 || err_s !== 1'b1) begin errors++; $display("FAIL bad%0d_done: cycle %0d err %b required 1/1", i, done_cyc, err_s); end
            checks++; if (re_cnt !== 0 || we_cnt !== 0) begin errors++; $display("FAIL bad%0d_no_access: re %0d we %0d required 0/0", i, re_cnt, we_cnt); end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        do_req(32'h8000_1010, 32'h0102_0304, 2'b10);
        checks++; if (we_addr !== 10'd4 || we_data !== 32'h0102_0304) begin errors++; $display("FAIL wrap_word: addr %h data %h required 004/01020304", we_addr, we_data); end
        do_req(32'hFFFF_F011, 32'h0000_00FF, 2'b00);
        checks++; if (we_addr !== 10'd4 || we_data !== 32'h0102_FF04) begin errors++; $display("FAIL wrap_byte: addr %h data %h required 004/0102ff04", we_addr, we_data); end
    endtask

    task automatic test_reset_mid();
        int wt;
        for (int k = 1; k <= 2; k++) begin
            apply_reset();
            preload(10'd4, 32'h1122_3344);
            wt = we_total;
            @(negedge clk);
            req_valid = 1'b1; req_addr = 32'h12; req_data = 32'h55; req_size = 2'b00;
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (k == 2) begin @(posedge clk); #1; end
            reset = 1'b0;
            #1;
            checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid%0d_state: busy %b ready %b required 0/1", k, busy, req_ready); end
            checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rstmid%0d_strobes: re %b we %b required 0/0", k, mem_re, mem_we); end
            repeat (2) @(negedge clk);
            reset = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            checks++; if (we_total !== wt) begin errors++; $display("FAIL rstmid%0d_no_write: writes %0d required %0d", k, we_total, wt); end
            checks++; if (mem[4] !== 32'h1122_3344) begin errors++; $display("FAIL rstmid%0d_mem: got %h required 11223344", k, mem[4]); end
        end
    endtask

    task automatic test_back_to_back();
        int we1, we2;
        logic [31:0] d1, d2;
        logic [9:0] a2;
        logic r3, r4;
        apply_reset();
        preload(10'd4, 32'h1122_3344);
        we1 = 0; we2 = 0; d1 = '0; d2 = '0; a2 = '0; r3 = 1'b1; r4 = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h12; req_data = 32'hAB; req_size = 2'b00;
        @(posedge clk); #1;
        req_addr = 32'h30; req_data = 32'h0BAD_F00D; req_size = 2'b10;
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) r3 = req_ready;
            if (c == 4) r4 = req_ready;
            if (mem_we && we1 == 0) begin we1 = c; d1 = mem_wdata; end
            else if (mem_we && we2 == 0) begin we2 = c; d2 = mem_wdata; a2 = mem_addr; req_valid = 1'b0; end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        checks++; if (we1 !== 3 || d1 !== 32'h11AB_3344) begin errors++; $display("FAIL b2b_first: cycle %0d data %h required 3/11ab3344", we1, d1); end
        checks++; if (r3 !== 1'b0 || r4 !== 1'b1) begin errors++; $display("FAIL b2b_ready: WR %b after %b required 0/1", r3, r4); end
        checks++; if (we2 !== 5 || a2 !== 10'd12 || d2 !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_second: cycle %0d addr %h data %h required 5/00c/0badf00d", we2, a2, d2); end
    endtask

    task automatic test_fwd();
        int exp_lat, exp_re;
`ifdef SB_MERGE_FWD_EN
        exp_lat = 1; exp_re = 0;
`else
        exp_lat = 3; exp_re = 1;
`endif
        apply_reset();
        do_req(32'h20, 32'hA5A5_A5A5, 2'b10);
        do_req(32'h21, 32'h3C, 2'b00);
        checks++; if (done_cyc !== exp_lat || re_cnt !== exp_re) begin errors++; $display("FAIL fwd_latency: done %0d reads %0d required %0d/%0d", done_cyc, re_cnt, exp_lat, exp_re); end
        checks++; if (we_addr !== 10'd8 || we_data !== 32'hA5A5_3CA5) begin errors++; $display("FAIL fwd_wdata: addr %h data %h required 008/a5a53ca5", we_addr, we_data); end
        preload(10'd9, 32'h0);
        do_req(32'h24, 32'h77, 2'b00);
        checks++; if (done_cyc !== 3 || we_data !== 32'h0000_0077) begin errors++; $display("FAIL fwd_miss: done %0d data %h required 3/00000077", done_cyc, we_data); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_merge();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_fwd();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
